// File: rtl/hex_byte_pager.sv
// hex_byte_pager: holds a multi-byte word and shows one byte at a time as
// two hex nibbles. The shown byte advances on a synchronised key press or on
// an auto-scroll timer. All outputs come from registers only.
//
// Interface semantics: load is a single-cycle strobe with no back-pressure.
// The word on data_in is captured on every rising edge where load is high
// and reset is low. There is no ready signal because capture always succeeds.
module hex_byte_pager #(
  parameter int  DATA_W   = 64,
  parameter int  TICK_DIV = 50_000_000,
  localparam int NB       = DATA_W / 8,
  localparam int IW       = $clog2(NB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              step_key,
  input  logic              auto_en,
  output logic              valid,
  output logic [IW-1:0]     byte_idx,
  output logic [3:0]        nib_hi,
  output logic [3:0]        nib_lo
);

  localparam int TW = $clog2(TICK_DIV);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] AUTO  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] held;
  logic [TW-1:0]     tick;
  logic              s1, s2, s3;
  logic              step;
  logic              terminal;
  logic [IW-1:0]     next_idx;

  // Rising-edge detect on the synchronised key, terminal tick, wrapping index.
  always_comb begin
    step     = s2 & ~s3;
    terminal = (tick == TW'(TICK_DIV - 1));
    next_idx = (byte_idx == IW'(NB - 1)) ? '0 : byte_idx + IW'(1);
  end

  // State, held word, byte index, scroll timer and key synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      held     <= '0;
      byte_idx <= '0;
      tick     <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
    end else begin
      s1 <= step_key;
      s2 <= s1;
      s3 <= s2;
      if (load) begin
        // A load outranks any step or terminal tick arriving in the same cycle.
        held     <= data_in;
        byte_idx <= '0;
        tick     <= '0;
        state    <= auto_en ? AUTO : SHOW;
      end else begin
        case (state)
          EMPTY: ;
          SHOW: begin
            if (step) byte_idx <= next_idx;
            if (auto_en) begin
              state <= AUTO;
              tick  <= '0;
            end
          end
          AUTO: begin
            if (!auto_en) begin
              state <= SHOW;
              tick  <= '0;
              if (step) byte_idx <= next_idx;
            end else if (step || terminal) begin
              // A step and a terminal tick in the same cycle give one advance.
              byte_idx <= next_idx;
              tick     <= '0;
            end else begin
              tick <= tick + TW'(1);
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  // Select the displayed byte from the held word.
  always_comb begin
    nib_hi = '0;
    nib_lo = '0;
    for (int b = 0; b < NB; b++) begin
      if (byte_idx == IW'(b)) begin
        nib_hi = held[b*8+4 +: 4];
        nib_lo = held[b*8 +: 4];
      end
    end
  end

  assign valid = (state != EMPTY);

endmodule

// File: tb/tb_hex_byte_pager.sv
// Directed bench for hex_byte_pager (DATA_W=32, TICK_DIV=4). A behavioural
// model tracks word, index and scroll timing. It is compared with the DUT on
// every falling edge, and literal checks pin key points of the sequence.
module tb_hex_byte_pager;

  localparam int DATA_W   = 32;
  localparam int TICK_DIV = 4;
  localparam int NB       = DATA_W / 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset    = 1'b1;
  logic              load     = 1'b0;
  logic [DATA_W-1:0] data_in  = '0;
  logic              step_key = 1'b0;
  logic              auto_en  = 1'b0;
  logic              valid;
  logic [1:0]        byte_idx;
  logic [3:0]        nib_hi;
  logic [3:0]        nib_lo;

  hex_byte_pager #(.DATA_W(DATA_W), .TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
    .step_key (step_key),
    .auto_en  (auto_en),
    .valid    (valid),
    .byte_idx (byte_idx),
    .nib_hi   (nib_hi),
    .nib_lo   (nib_lo)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: key samples from the last three edges, newest in [0]
  bit              m_valid = 1'b0;
  bit              m_auto  = 1'b0;
  int              m_idx   = 0;
  int              m_cnt   = 0;
  logic [DATA_W-1:0] m_word = '0;
  bit [2:0]        m_hist  = '0;

  always @(posedge clk) begin
    bit press;
    if (reset) begin
      m_valid = 1'b0;
      m_auto  = 1'b0;
      m_idx   = 0;
      m_cnt   = 0;
      m_word  = '0;
      m_hist  = '0;
    end else begin
      // a press is seen two edges after the key was first sampled high
      press = m_hist[1] && !m_hist[2];
      if (load) begin
        m_word  = data_in;
        m_idx   = 0;
        m_cnt   = 0;
        m_valid = 1'b1;
        m_auto  = auto_en;
      end else if (m_valid) begin
        if (m_auto && !auto_en) begin
          m_auto = 1'b0;
          m_cnt  = 0;
          if (press) m_idx = (m_idx + 1) % NB;
        end else if (m_auto) begin
          if (press || m_cnt == TICK_DIV - 1) begin
            m_idx = (m_idx + 1) % NB;
            m_cnt = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          if (press) m_idx = (m_idx + 1) % NB;
          if (auto_en) begin
            m_auto = 1'b1;
            m_cnt  = 0;
          end
        end
      end
      m_hist = {m_hist[1:0], step_key};
    end
  end

  // compare process: DUT against model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(valid), 32'(m_valid));
      check("byte_idx", 32'(byte_idx), 32'(m_idx));
      check("nib_hi", 32'(nib_hi), (m_word >> (8 * m_idx + 4)) & 32'hF);
      check("nib_lo", 32'(nib_lo), (m_word >> (8 * m_idx)) & 32'hF);
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key(input int hold, input int gap);
    step_key = 1'b1;
    cyc(hold);
    step_key = 1'b0;
    cyc(gap);
  endtask

  task automatic pin(input string name, input logic [1:0] idx, input logic [3:0] hi, input logic [3:0] lo);
    check({name, "_idx"}, 32'(byte_idx), 32'(idx));
    check({name, "_hi"}, 32'(nib_hi), 32'(hi));
    check({name, "_lo"}, 32'(nib_lo), 32'(lo));
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_valid", 32'(valid), 32'd0);
    pin("rst", 2'd0, 4'h0, 4'h0);

    // key activity while empty
    press_key(5, 5);
    check("empty_valid", 32'(valid), 32'd0);
    pin("empty", 2'd0, 4'h0, 4'h0);

    // load, manual scroll
    data_in = 32'hDEADBEEF;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("load_valid", 32'(valid), 32'd1);
    pin("load", 2'd0, 4'hE, 4'hF);

    step_key = 1'b1;
    cyc(2);
    pin("lat_k1", 2'd0, 4'hE, 4'hF);
    cyc(1);
    pin("lat_k2", 2'd1, 4'hB, 4'hE);
    cyc(2);
    step_key = 1'b0;
    cyc(5);
    pin("press1", 2'd1, 4'hB, 4'hE);
    press_key(5, 5);
    pin("press2", 2'd2, 4'hA, 4'hD);
    press_key(5, 5);
    pin("press3", 2'd3, 4'hD, 4'hE);
    press_key(5, 5);
    pin("press4_wrap", 2'd0, 4'hE, 4'hF);

    // load straight into auto-scroll
    load = 1'b1;
    auto_en = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(3);
    pin("auto_t3", 2'd0, 4'hE, 4'hF);
    cyc(1);
    pin("auto_a1", 2'd1, 4'hB, 4'hE);
    cyc(4);
    pin("auto_a2", 2'd2, 4'hA, 4'hD);
    cyc(4);
    pin("auto_a3", 2'd3, 4'hD, 4'hE);
    cyc(4);
    pin("auto_a4", 2'd0, 4'hE, 4'hF);

    // pause mid-count, then resume
    cyc(2);
    auto_en = 1'b0;
    cyc(7);
    pin("paused", 2'd0, 4'hE, 4'hF);
    auto_en = 1'b1;
    cyc(1);
    cyc(3);
    pin("resume_t3", 2'd0, 4'hE, 4'hF);
    cyc(1);
    pin("resume_a1", 2'd1, 4'hB, 4'hE);

    // back to manual, step to index 2, then load on a step edge
    auto_en = 1'b0;
    cyc(1);
    press_key(5, 5);
    pin("pre_load", 2'd2, 4'hA, 4'hD);
    step_key = 1'b1;
    cyc(2);
    data_in = 32'h12345678;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    pin("load_vs_step", 2'd0, 4'h7, 4'h8);
    cyc(3);
    step_key = 1'b0;
    cyc(5);
    pin("held_key_once", 2'd0, 4'h7, 4'h8);

    // step edge landing on the terminal tick
    auto_en = 1'b1;
    cyc(1);
    cyc(1);
    step_key = 1'b1;
    cyc(2);
    pin("coinc_pre", 2'd0, 4'h7, 4'h8);
    cyc(1);
    step_key = 1'b0;
    pin("coinc_single", 2'd1, 4'h5, 4'h6);
    cyc(3);
    pin("coinc_hold", 2'd1, 4'h5, 4'h6);
    cyc(1);
    pin("coinc_next", 2'd2, 4'h3, 4'h4);

    // non-terminal step in auto restarts the timer
    step_key = 1'b1;
    cyc(3);
    pin("auto_step", 2'd3, 4'h1, 4'h2);
    step_key = 1'b0;
    cyc(3);
    pin("auto_restart", 2'd3, 4'h1, 4'h2);
    cyc(1);
    pin("auto_after", 2'd0, 4'h7, 4'h8);
    cyc(12);
    pin("auto_idx3", 2'd3, 4'h1, 4'h2);

    // reset while scrolling
    reset = 1'b1;
    cyc(1);
    check("mid_rst_valid", 32'(valid), 32'd0);
    pin("mid_rst", 2'd0, 4'h0, 4'h0);
    cyc(1);
    reset = 1'b0;
    auto_en = 1'b0;
    cyc(6);
    check("post_rst_valid", 32'(valid), 32'd0);
    pin("post_rst", 2'd0, 4'h0, 4'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
